// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port, resolves branches,
// stalls upstream while a load/store is outstanding and registers MEM/WB fields.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int BT_W    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              step_clk,
  input  logic              reset,
  input  logic [BT_W-1:0]   branch_target_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic              alu_zero_in,
  input  logic [DATA_W-1:0] read_data2_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [1:0]        wb_in,
  input  logic [2:0]        m_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [BT_W-1:0]   branch_target_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic [1:0]        wb_out,
  output logic              misalign,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [REG_W-1:0]   wreg_q, wreg_d;
  logic [1:0]         wb_q, wb_d;
  logic               mis_q, mis_d;
  logic               berr_q, berr_d;
  logic               stall_c;

  logic mem_op, aligned;
  assign mem_op  = m_in[1] | m_in[0];
  assign aligned = (alu_result_in[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    wb_d    = wb_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          alu_d   = alu_result_in;
          wreg_d  = write_reg_in;
          wb_d    = wb_in;
          rdata_d = '0;
        end else if (!aligned) begin
          alu_d   = alu_result_in;
          wreg_d  = write_reg_in;
          wb_d    = 2'b00;
          rdata_d = '0;
          mis_d   = 1'b1;
        end else begin
          // Issue: latch the request; read+write together counts as a write.
          stall_c = 1'b1;
          addr_d  = alu_result_in;
          wdata_d = read_data2_in;
          we_d    = m_in[0];
          req_d   = 1'b1;
          cnt_d   = '0;
          wb_d    = 2'b00;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          rdata_d = we_q ? '0 : dmem_rdata;
          alu_d   = alu_result_in;
          wreg_d  = write_reg_in;
          wb_d    = wb_in;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: release upstream and drop the instruction's writeback.
          rdata_d = '0;
          wb_d    = 2'b00;
          req_d   = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          wb_d    = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge step_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      wb_q    <= 2'b00;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign stall             = stall_c;
  assign pc_src            = m_in[2] & alu_zero_in & ~stall_c;
  assign branch_target_out = branch_target_in;
  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign read_data_out     = rdata_q;
  assign alu_result_out    = alu_q;
  assign write_reg_out     = wreg_q;
  assign wb_out            = wb_q;
  assign misalign          = mis_q;
  assign bus_err           = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, branch, load/store
// handshakes, misalignment, timeout abort and reset during an outstanding access.
module tb_mem_stage;

  logic        step_clk = 1'b0;
  logic        reset;
  logic [63:0] branch_target_in;
  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic [31:0] read_data2_in;
  logic [3:0]  write_reg_in;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src;
  logic [63:0] branch_target_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [3:0]  write_reg_out;
  logic [1:0]  wb_out;
  logic        misalign, bus_err;

  int checks = 0;
  int failures = 0;

  mem_stage #(.DATA_W(32), .REG_W(4), .BT_W(64), .TIMEOUT(16)) dut (
    .step_clk(step_clk), .reset(reset),
    .branch_target_in(branch_target_in), .alu_result_in(alu_result_in),
    .alu_zero_in(alu_zero_in), .read_data2_in(read_data2_in),
    .write_reg_in(write_reg_in), .wb_in(wb_in), .m_in(m_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .branch_target_out(branch_target_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .wb_out(wb_out),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 step_clk = ~step_clk;

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge step_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] d2, input logic [3:0] wr, input logic z);
    m_in = m; wb_in = wb; alu_result_in = alu; read_data2_in = d2;
    write_reg_in = wr; alu_zero_in = z;
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    branch_target_in = 64'h0;
    drive(3'b000, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b0);
    tick(); tick();
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", dmem_we); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin failures++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", dmem_addr, dmem_wdata); end
    checks++; if (read_data_out !== 32'h0 || alu_result_out !== 32'h0) begin failures++; $display("FAIL rst_mwb_data got=%h/%h exp=0/0", read_data_out, alu_result_out); end
    checks++; if (write_reg_out !== 4'h0 || wb_out !== 2'b00) begin failures++; $display("FAIL rst_mwb_ctl got=%h/%b exp=0/00", write_reg_out, wb_out); end
    checks++; if (misalign !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b/%b exp=0/0", misalign, bus_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    drive(3'b000, 2'b10, 32'h1234, 32'h0, 4'd5, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    checks++; if (alu_result_out !== 32'h1234) begin failures++; $display("FAIL alu_result got=%h exp=00001234", alu_result_out); end
    checks++; if (write_reg_out !== 4'd5) begin failures++; $display("FAIL alu_wreg got=%0d exp=5", write_reg_out); end
    checks++; if (wb_out !== 2'b10) begin failures++; $display("FAIL alu_wb got=%b exp=10", wb_out); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL alu_req got=%b exp=0", dmem_req); end
  endtask

  task automatic test_branch();
    branch_target_in = 64'hCAFE_0000_1234_5678;
    drive(3'b100, 2'b00, 32'h0, 32'h0, 4'd0, 1'b1);
    #1;
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL br_taken got=%b exp=1", pc_src); end
    checks++; if (branch_target_out !== 64'hCAFE_0000_1234_5678) begin failures++; $display("FAIL br_target got=%h exp=cafe000012345678", branch_target_out); end
    alu_zero_in = 1'b0;
    #1;
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%b exp=0", pc_src); end
    tick();
  endtask

  task automatic test_load();
    int stalls = 0;
    drive(3'b010, 2'b11, 32'h40, 32'h0, 4'd7, 1'b1);
    #1;
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL ld_issue stall/req got=%b/%b exp=1/0", stall, dmem_req); end
    if (stall === 1'b1) stalls++;
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin failures++; $display("FAIL ld_req req/we/addr got=%b/%b/%h exp=1/0/00000040", dmem_req, dmem_we, dmem_addr); end
    for (int k = 0; k < 3; k++) begin
      #1;
      if (stall === 1'b1) stalls++;
      checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL ld_pcsrc_in_stall got=%b exp=0", pc_src); end
      tick();
      checks++; if (wb_out !== 2'b00 || dmem_req !== 1'b1 || dmem_addr !== 32'h40) begin failures++; $display("FAIL ld_busy wb/req/addr got=%b/%b/%h exp=00/1/00000040", wb_out, dmem_req, dmem_addr); end
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ld_ack_stall got=%b exp=0", stall); end
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++; if (stalls !== 4) begin failures++; $display("FAIL ld_stall_cycles got=%0d exp=4", stalls); end
    checks++; if (read_data_out !== 32'hDEAD_BEEF || wb_out !== 2'b11) begin failures++; $display("FAIL ld_result rdata/wb got=%h/%b exp=deadbeef/11", read_data_out, wb_out); end
    checks++; if (dmem_req !== 1'b0 || write_reg_out !== 4'd7) begin failures++; $display("FAIL ld_done req/wreg got=%b/%0d exp=0/7", dmem_req, write_reg_out); end
    drive(3'b000, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0);
    tick();
  endtask

  task automatic test_store();
    int stalls = 0;
    drive(3'b001, 2'b00, 32'h44, 32'hA5A5_A5A5, 4'd0, 1'b0);
    #1;
    if (stall === 1'b1) stalls++;
    tick();
    checks++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'hA5A5_A5A5 || dmem_addr !== 32'h44) begin failures++; $display("FAIL st_req we/wdata/addr got=%b/%h/%h exp=1/a5a5a5a5/00000044", dmem_we, dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1;
    #1;
    if (stall === 1'b1) stalls++;
    tick();
    dmem_ack = 1'b0;
    checks++; if (stalls !== 1) begin failures++; $display("FAIL st_stall_cycles got=%0d exp=1", stalls); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL st_done_req got=%b exp=0", dmem_req); end
  endtask

  task automatic test_read_write();
    // Read and write both set behaves as a write with zero load data.
    drive(3'b011, 2'b11, 32'h48, 32'h0000_0011, 4'd3, 1'b0);
    tick();
    checks++; if (dmem_we !== 1'b1) begin failures++; $display("FAIL rw_we got=%b exp=1", dmem_we); end
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    checks++; if (read_data_out !== 32'h0 || wb_out !== 2'b11) begin failures++; $display("FAIL rw_result rdata/wb got=%h/%b exp=00000000/11", read_data_out, wb_out); end
  endtask

  task automatic test_misalign();
    drive(3'b010, 2'b11, 32'h41, 32'h0, 4'd9, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall); end
    tick();
    checks++; if (misalign !== 1'b1 || dmem_req !== 1'b0 || wb_out !== 2'b00) begin failures++; $display("FAIL mis_pulse mis/req/wb got=%b/%b/%b exp=1/0/00", misalign, dmem_req, wb_out); end
    checks++; if (alu_result_out !== 32'h41 || write_reg_out !== 4'd9) begin failures++; $display("FAIL mis_fields alu/wreg got=%h/%0d exp=00000041/9", alu_result_out, write_reg_out); end
    drive(3'b000, 2'b01, 32'h8, 32'h0, 4'd1, 1'b0);
    tick();
    checks++; if (misalign !== 1'b0 || wb_out !== 2'b01) begin failures++; $display("FAIL mis_clear mis/wb got=%b/%b exp=0/01", misalign, wb_out); end
  endtask

  task automatic test_timeout();
    int busy = 0;
    int stalls = 0;
    drive(3'b010, 2'b11, 32'h80, 32'h0, 4'd2, 1'b0);
    tick();
    for (int k = 0; k < 40; k++) begin
      if (dmem_req !== 1'b1) break;
      busy++;
      #1;
      if (stall === 1'b1) stalls++;
      else drive(3'b000, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0);
      tick();
    end
    checks++; if (busy !== 16) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=16", busy); end
    checks++; if (stalls !== 15) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=15", stalls); end
    checks++; if (bus_err !== 1'b1 || wb_out !== 2'b00 || read_data_out !== 32'h0) begin failures++; $display("FAIL to_abort berr/wb/rdata got=%b/%b/%h exp=1/00/00000000", bus_err, wb_out, read_data_out); end
    drive(3'b000, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0);
    tick();
    checks++; if (bus_err !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL to_clear berr/req got=%b/%b exp=0/0", bus_err, dmem_req); end
  endtask

  task automatic test_reset_mid_busy();
    // Seed non-zero load data so the reset clearing it is visible.
    drive(3'b010, 2'b11, 32'h90, 32'h0, 4'd4, 1'b0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_ack = 1'b0;
    drive(3'b001, 2'b00, 32'h94, 32'h77, 4'd0, 1'b0);
    tick(); tick();
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rmb_busy_req got=%b exp=1", dmem_req); end
    reset = 1'b1;
    drive(3'b000, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0);
    tick();
    reset = 1'b0;
    checks++; if (dmem_req !== 1'b0 || read_data_out !== 32'h0) begin failures++; $display("FAIL rmb_req_rdata got=%b/%h exp=0/00000000", dmem_req, read_data_out); end
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmb_late_ack_stall got=%b exp=0", stall); end
    tick();
    dmem_ack = 1'b0;
    checks++; if (dmem_req !== 1'b0 || read_data_out !== 32'h0) begin failures++; $display("FAIL rmb_late_ack got=%b/%h exp=0/00000000", dmem_req, read_data_out); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store();
    test_read_write();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
